// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the object-draw arbiter and the drawer.
// Build option: OBJECT_DRAW_ARB_RR_EN selects round-robin arbitration
// (default build is fixed priority, index 0 highest).
package draw_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    // Width of the saturating watchdog counter
    localparam int WDOG_W = 16;

    // Default object field widths, shared with the drawer
    localparam int DEF_TYPE_W = 5;
    localparam int DEF_X_W    = 9;
    localparam int DEF_Y_W    = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational one-hot picker: the first asserted request at or after
// ptr, searching cyclically. With ptr tied to zero it is a plain
// lowest-index-wins priority encoder.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    // Scan requesters starting at ptr and keep only the first hit
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/object_draw_arbiter.sv
// Shares the single object-drawing engine among NUM_REQ requesters.
// Serialises requests, latches the winner's type/coordinates, pulses the
// drawer start for one cycle, waits for completion (guarded by a
// saturating watchdog) and returns a one-cycle done to the owner.
// Build option: OBJECT_DRAW_ARB_RR_EN enables round-robin arbitration;
// without it the lowest-index requester always wins. Timing is identical.
module object_draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                TYPE_W  = DEF_TYPE_W,
    parameter int                X_W     = DEF_X_W,
    parameter int                Y_W     = DEF_Y_W,
    parameter logic [WDOG_W-1:0] TIMEOUT = 16'd40000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*TYPE_W-1:0]  req_type,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic                       start_draw_object,
    output logic [TYPE_W-1:0]          object_type,
    output logic [X_W-1:0]             x_start,
    output logic [Y_W-1:0]             y_start,
    input  logic                       draw_object_done,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [TYPE_W-1:0]   type_q,  type_d;
    logic [X_W-1:0]      x_q,     x_d;
    logic [Y_W-1:0]      y_q,     y_d;
    logic                err_q,   err_d;
    logic [WDOG_W-1:0]   wdog_q,  wdog_d;

    logic [NUM_REQ-1:0]  winner;
    logic [PTR_W-1:0]    pick_ptr;
    logic                wdog_expired;

`ifdef OBJECT_DRAW_ARB_RR_EN
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    // Fixed priority: the search always starts at requester 0
    assign pick_ptr = '0;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner)
    );

    // A zero TIMEOUT disables the watchdog entirely
    assign wdog_expired = (TIMEOUT != '0) && (wdog_q == TIMEOUT - 1'b1);

    // Next-state and next-field computation for the arbiter sequence
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        type_d  = type_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
`ifdef OBJECT_DRAW_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ISSUE;
                    grant_d = winner;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winner[i]) begin
                            type_d = req_type[i*TYPE_W +: TYPE_W];
                            x_d    = req_x[i*X_W +: X_W];
                            y_d    = req_y[i*Y_W +: Y_W];
`ifdef OBJECT_DRAW_ARB_RR_EN
                            ptr_d  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
`endif
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wdog_d  = '0;
            end
            WAIT: begin
                // Saturate rather than wrap so a stuck count can never re-arm
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // A real completion takes precedence over a same-cycle timeout
                if (draw_object_done) begin
                    state_d = ACK;
                    err_d   = 1'b0;
                end else if (wdog_expired) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-field registers; reset abandons any in-flight draw
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            type_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
`ifdef OBJECT_DRAW_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            type_q  <= type_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
`ifdef OBJECT_DRAW_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Outputs decoded from registered state only, so reset clears them at once
    assign grant             = grant_q;
    assign done              = (state_q == ACK) ? grant_q : '0;
    assign err               = (state_q == ACK) && err_q;
    assign start_draw_object = (state_q == ISSUE);
    assign busy              = (state_q != IDLE);
    assign object_type       = type_q;
    assign x_start           = x_q;
    assign y_start           = y_q;

endmodule

// File: tb/tb_object_draw_arbiter.sv
// Randomised scoreboard bench for object_draw_arbiter.
// Stimulus predicts the service order from the arbitration rules and
// pushes expected completions; a separate monitor pops and compares.
module tb_object_draw_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          TYPE_W  = 5;
    localparam int          X_W     = 9;
    localparam int          Y_W     = 8;
    localparam logic [15:0] TIMEOUT = 16'd16;
    localparam int          WD_LAT  = 17;   // ISSUE to done when the drawer never answers

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TYPE_W-1:0] req_type;
    logic [NUM_REQ*X_W-1:0]    req_x;
    logic [NUM_REQ*Y_W-1:0]    req_y;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic                      start_draw_object;
    logic [TYPE_W-1:0]         object_type;
    logic [X_W-1:0]            x_start;
    logic [Y_W-1:0]            y_start;
    logic                      draw_object_done;
    logic                      busy;

    object_draw_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TYPE_W  (TYPE_W),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_type          (req_type),
        .req_x             (req_x),
        .req_y             (req_y),
        .grant             (grant),
        .done              (done),
        .err               (err),
        .start_draw_object (start_draw_object),
        .object_type       (object_type),
        .x_start           (x_start),
        .y_start           (y_start),
        .draw_object_done  (draw_object_done),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                idx;
        logic [TYPE_W-1:0] typ;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic              err;
        int                lat;
        bit                first;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];

    int checks = 0;
    int errors = 0;

    int raise_cyc     = 0;
    int last_done_cyc = 0;
    int start_cyc     = 0;
    int model_ptr     = 0;

    logic [TYPE_W-1:0] d_type [NUM_REQ];
    logic [X_W-1:0]    d_x    [NUM_REQ];
    logic [Y_W-1:0]    d_y    [NUM_REQ];

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Drawer model: answers each start after the planned latency (0 = never),
    // and sprinkles stray completions in IDLE and ISSUE that must be ignored.
    initial begin
        int L;
        draw_object_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                draw_object_done = 1'b0;
            end else if (start_draw_object) begin
                L = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                draw_object_done = ($urandom_range(0, 2) == 0);
                for (int j = 1; j <= L; j++) begin
                    @(negedge clk);
                    draw_object_done = (j == L);
                end
                @(negedge clk);
                draw_object_done = 1'b0;
            end else begin
                draw_object_done = !busy && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: compares every start and every done against the scoreboard
    initial begin
        exp_t               e;
        bit                 prev_start;
        logic [NUM_REQ-1:0] oh;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
            end else begin
                if (prev_start)
                    check(start_draw_object == 1'b0, "start_one_cycle", 32'(start_draw_object), 0);
                prev_start = start_draw_object;

                if (start_draw_object) begin
                    start_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_start", 32'(grant), 0);
                    end else begin
                        e  = exp_q[0];
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        check(grant == oh, "grant_at_start", 32'(grant), 32'(oh));
                        check({object_type, x_start, y_start} == {e.typ, e.x, e.y}, "fields_at_start",
                              32'({object_type, x_start, y_start}), 32'({e.typ, e.x, e.y}));
                        if (e.first)
                            check(cyc == raise_cyc + 1, "start_latency", 32'(cyc - raise_cyc), 1);
                        else
                            check(cyc == last_done_cyc + 2, "turnaround", 32'(cyc - last_done_cyc), 2);
                    end
                end

                if (done != '0) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_done", 32'(done), 0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        check(done == oh, "done_owner", 32'(done), 32'(oh));
                        check(grant == oh, "grant_in_ack", 32'(grant), 32'(oh));
                        check(err == e.err, "err_flag", 32'(err), 32'(e.err));
                        check(cyc - start_cyc == e.lat, "draw_latency", 32'(cyc - start_cyc), 32'(e.lat));
                        check({object_type, x_start, y_start} == {e.typ, e.x, e.y}, "fields_at_ack",
                              32'({object_type, x_start, y_start}), 32'({e.typ, e.x, e.y}));
                        check(busy == 1'b1, "busy_in_ack", 32'(busy), 1);
                        last_done_cyc = cyc;
                    end
                end else begin
                    check(err == 1'b0, "err_outside_ack", 32'(err), 0);
                end
            end
        end
    end

    task automatic set_random_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            d_type[i] = TYPE_W'($urandom);
            d_x[i]    = X_W'($urandom);
            d_y[i]    = Y_W'($urandom);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_type[i*TYPE_W +: TYPE_W] = d_type[i];
            req_x[i*X_W +: X_W]          = d_x[i];
            req_y[i*Y_W +: Y_W]          = d_y[i];
        end
    endtask

    task automatic pulse_reset();
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        model_ptr = 0;
    endtask

    // Raise a set of requests together. Requester again_idx asks twice
    // (keeps req high through the cycle after its first done).
    // forced_lat < 0 picks a random drawer latency per draw.
    task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int again_idx,
                             input int forced_lat);
        int pending [NUM_REQ];
        int again   [NUM_REQ];
        int total;
        int n;
        int L;
        int w;
        exp_t e;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = mask[i] ? ((i == again_idx) ? 2 : 1) : 0;
            again[i]   = (mask[i] && i == again_idx) ? 1 : 0;
            total     += pending[i];
        end
        // Service order straight from the arbitration rule
        n = 0;
        while (total > 0) begin
            w = -1;
            for (int off = 0; off < NUM_REQ; off++) begin
                if (w < 0 && pending[(model_ptr + off) % NUM_REQ] > 0)
                    w = (model_ptr + off) % NUM_REQ;
            end
            pending[w]--;
            total--;
`ifdef OBJECT_DRAW_ARB_RR_EN
            model_ptr = (w + 1) % NUM_REQ;
`endif
            if (forced_lat >= 0) L = forced_lat;
            else L = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
            e.idx   = w;
            e.typ   = d_type[w];
            e.x     = d_x[w];
            e.y     = d_y[w];
            e.err   = (L == 0);
            e.lat   = (L == 0) ? WD_LAT : L + 1;
            e.first = (n == 0);
            exp_q.push_back(e);
            lat_q.push_back(L);
            n++;
        end
        drive_data();
        raise_cyc = cyc;
        req = mask;
        // Requester behaviour: drop req right after done unless asking again
        for (int c = 0; c < 40 * n + 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i]) begin
                    if (again[i] > 0) again[i]--;
                    else req[i] = 1'b0;
                end
            end
        end
        if (exp_q.size() != 0) begin
            check(1'b0, "batch_timeout", 32'(exp_q.size()), 0);
            pulse_reset();
        end else begin
            @(negedge clk);
            #1;
            check(busy == 1'b0 && grant == '0, "idle_after_ack", 32'({busy, grant}), 0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({grant, done, err, start_draw_object, busy} == '0, name,
              32'({grant, done, err, start_draw_object, busy}), 0);
        check({object_type, x_start, y_start} == '0, name,
              32'({object_type, x_start, y_start}), 0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] m;
        reset    = 1'b1;
        req      = '0;
        req_type = '0;
        req_x    = '0;
        req_y    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("after_reset");

        // Single request, drawer answers 11 cycles after start
        set_random_data();
        d_type[1] = 5'd12;
        d_x[1]    = 9'd100;
        d_y[1]    = 8'd20;
        run_batch(4'b0010, -1, 11);

        // Watchdog abort, then the same-cycle done/timeout boundary
        set_random_data();
        run_batch(4'b0001, -1, 0);
        set_random_data();
        run_batch(4'b1000, -1, 16);

        // Contention with re-raised requesters
        set_random_data();
        run_batch(4'b1111, 0, -1);
        set_random_data();
        run_batch(4'b1010, 1, -1);

        // Reset in the middle of WAIT: no done may ever appear for it
        set_random_data();
        run_batch_abort();

        set_random_data();
        run_batch(4'b0001, -1, 5);

        // Randomised batches
        for (int t = 0; t < 30; t++) begin
            set_random_data();
            m = NUM_REQ'($urandom_range(1, 15));
            run_batch(m, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic run_batch_abort();
        exp_t e;
        int   c;
        e.idx   = 2;
        e.typ   = d_type[2];
        e.x     = d_x[2];
        e.y     = d_y[2];
        e.err   = 1'b1;
        e.lat   = WD_LAT;
        e.first = 1'b1;
        exp_q.push_back(e);
        lat_q.push_back(0);
        drive_data();
        raise_cyc = cyc;
        req = 4'b0100;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!start_draw_object && c < 10);
        check(start_draw_object == 1'b1, "abort_start_seen", 32'(start_draw_object), 1);
        repeat (4) @(negedge clk);
        #2;
        check(busy == 1'b1, "busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset_midwait");
        req = '0;
        exp_q.delete();
        lat_q.delete();
        model_ptr = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        check(busy == 1'b0 && done == '0, "quiet_after_abort", 32'({busy, done}), 0);
    endtask

endmodule
